spi_tx: RTL



---
 rtl/spi_tx_if.sv | 38 +++
 rtl/spi_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_if.sv
// spi_tx_if: parallel word handshake, SPI pins and status of spi_tx.
// When SPI_TX_RX_CAPTURE_EN is defined the interface also carries sdi/rx_data.
interface spi_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             sck;
  logic             sdo;
  logic             ce;
  logic             busy;
  logic             done;
`ifdef SPI_TX_RX_CAPTURE_EN
  logic             sdi;
  logic [WIDTH-1:0] rx_data;

  modport master (
    output tx_data, tx_valid, sdi,
    input  tx_ready, sck, sdo, ce, busy, done, rx_data
  );

  modport slave (
    input  tx_data, tx_valid, sdi,
    output tx_ready, sck, sdo, ce, busy, done, rx_data
  );
`else
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, sck, sdo, ce, busy, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, sck, sdo, ce, busy, done
  );
`endif
endinterface

// File: rtl/spi_tx.sv
// spi_tx: SPI mode-0 controller-side transmitter. Accepts a WIDTH-bit word on
// a valid/ready handshake and shifts it out MSB-first framed by active-high ce.
// sck half-period is CLK_DIV clk cycles; ce stays low for CE_GAP cycles after
// each word before the block returns to idle.
// Optional build macro SPI_TX_RX_CAPTURE_EN adds sdi sampling into rx_data.
module spi_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CE_GAP  = 2
) (
  input  logic    clk,
  input  logic    reset,
  spi_tx_if.slave bus
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int unsigned GW = (CE_GAP > 0) ? $clog2(CE_GAP + 1) : 1;

  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [DW-1:0]    div_q,   div_d;
  logic [GW-1:0]    gap_q,   gap_d;
  logic             sck_q,   sck_d;
  logic             sdo_q,   sdo_d;
  logic             ce_q,    ce_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             ready_q, ready_d;
`ifdef SPI_TX_RX_CAPTURE_EN
  logic [WIDTH-1:0] rxs_q,   rxs_d;
  logic [WIDTH-1:0] rx_q,    rx_d;
`endif

  // Next-state and next-output logic; every output is registered, so each
  // output value is decided here on the transition into the phase it belongs to.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    ce_d    = ce_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef SPI_TX_RX_CAPTURE_EN
    rxs_d   = rxs_q;
    rx_d    = rx_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (bus.tx_valid && ready_q) begin
          state_d = SETUP;
          shift_d = bus.tx_data;
          bit_d   = BIT_LOAD;
          div_d   = DIV_LOAD;
          ce_d    = 1'b1;
          sck_d   = 1'b0;
          sdo_d   = bus.tx_data[WIDTH-1];
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (div_q == '0) begin
          state_d = HIGH;
          div_d   = DIV_LOAD;
          sck_d   = 1'b1;
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      HIGH: begin
        if (div_q == '0) begin
          state_d = LOW;
          div_d   = DIV_LOAD;
          sck_d   = 1'b0;
`ifdef SPI_TX_RX_CAPTURE_EN
          rxs_d   = {rxs_q[WIDTH-2:0], bus.sdi};
`endif
          // sdo moves to the next bit together with the falling sck edge,
          // giving the receiver a full LOW phase of setup before its next rise.
          if (bit_q != '0) begin
            shift_d = shift_q << 1;
            sdo_d   = shift_q[WIDTH-2];
          end
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      LOW: begin
        if (div_q == '0) begin
          if (bit_q == '0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
            ce_d    = 1'b0;
            sdo_d   = 1'b0;
            done_d  = 1'b1;
`ifdef SPI_TX_RX_CAPTURE_EN
            rx_d    = rxs_q;
`endif
          end else begin
            state_d = HIGH;
            bit_d   = bit_q - BW'(1);
            div_d   = DIV_LOAD;
            sck_d   = 1'b1;
          end
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef SPI_TX_RX_CAPTURE_EN
      rxs_q   <= '0;
      rx_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef SPI_TX_RX_CAPTURE_EN
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
`endif
    end
  end

  assign bus.sck      = sck_q;
  assign bus.sdo      = sdo_q;
  assign bus.ce       = ce_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tx_ready = ready_q;
`ifdef SPI_TX_RX_CAPTURE_EN
  assign bus.rx_data  = rx_q;
`endif

endmodule
